decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage of the 5-stage pipelined core: consumes InstrD/PCp1D from the Fetch IF/ID register and
//  returns the redirect controls (PCSelD, JumpD, PCBranchD, PCJumpD) that Fetch consumes.
//  Holds the register file, main/ALU control decoder, early branch compare and the ID/EX pipeline register.
// PARAMETERS
//  DWL    32  datapath / instruction width
//  RAWL   5   register-address width; register file depth 2**RAWL
// PORTS
//  CLK        in   1     clock, all state on rising edge
//  RST_N      in   1     asynchronous, active-low reset
//  EN         in   1     1 = ID/EX register loads; 0 = hold (load-use stall)
//  FlushE     in   1     synchronous bubble insert into ID/EX
//  InstrD     in   DWL   instruction from IF/ID
//  PCp1D      in   DWL   PC+1 from IF/ID (word-addressed PC)
//  RegWriteW  in   1     writeback enable
//  WriteRegW  in   RAWL  writeback register
//  ResultW    in   DWL   writeback data
//  ALUOutM    in   DWL   forwarding source for branch compare
//  ForwardAD  in   1     1 = compare operand A from ALUOutM
//  ForwardBD  in   1     1 = compare operand B from ALUOutM
//  PCSelD     out  1     branch taken (also clears IF/ID in Fetch)
//  JumpD      out  1     jump
//  PCBranchD  out  DWL   PCp1D + SignImm
//  PCJumpD    out  DWL   {PCp1D[31:26], InstrD[25:0]}
//  BranchD    out  1     decoded branch, for hazard unit
//  RsD,RtD    out  RAWL  source fields, for hazard unit
//  RegWriteE,MemtoRegE,MemWriteE,ALUSrcE,RegDstE  out 1 each  registered controls
//  ALUControlE  out  3   registered ALU op
//  RD1E,RD2E,SignImmE  out  DWL  registered operands
//  RsE,RtE,RdE  out  RAWL  registered register fields
//  IllegalE   out  1     registered undefined-opcode flag
// BEHAVIOUR
//  - Fields: op=[31:26] rs=[25:21] rt=[20:16] rd=[15:11] imm=[15:0] funct=[5:0]; SignImm = sign-extend imm.
//  - Opcodes: R=0x00 LW=0x23 SW=0x2B BEQ=0x04 ADDI=0x08 J=0x02; funct ADD=0x20 SUB=0x22 AND=0x24 OR=0x25 SLT=0x2A.
//  - ALUControl: ADD 010, SUB 110, AND 000, OR 001, SLT 111; LW/SW/ADDI use 010, BEQ 110.
//  - Undefined opcode/funct: all controls 0 (NOP), Illegal=1.
//  - Register file: 2**RAWL x DWL, two combinational reads, one write on CLK when RegWriteW && WriteRegW!=0.
//    Register 0 reads 0 always. Same-cycle read of WriteRegW returns ResultW (write-through bypass).
//  - Branch compare: A = ForwardAD ? ALUOutM : RD1, B = ForwardBD ? ALUOutM : RD2; PCSelD = BranchD && (A==B).
//  - PCBranchD wraps modulo 2**DWL; PCSelD/JumpD/PCBranchD/PCJumpD purely combinational, same cycle.
//  - ID/EX register priority: RST_N low (async) > FlushE > EN > hold. RST_N or FlushE: all *E outputs 0.
//    FlushE with EN=0 still bubbles. Latency InstrD -> *E outputs: 1 cycle.
//  - Reset: register file cleared to 0, all *E outputs 0; deassertion mid-program resumes from current IF/ID.
// CONFIGURATION
//  DECODE_BNE_EN defined: adds BNE=0x05, ALUControl 110, PCSelD = BranchD && (A!=B).
//  Not defined: 0x05 is undefined -> NOP, IllegalE=1, PCSelD=0.
// TESTING
//  - Reset low mid-run: *E outputs and every register read 0 immediately, before next CLK edge.
//  - Write R5=0x1234 via W port, same cycle InstrD reads rs=5 -> RD1 bypass 0x1234; next cycle RD1E=0x1234.
//  - BEQ r1,r2,imm=0xFFFE with r1==r2, PCp1D=0x10 -> PCSelD=1, PCBranchD=0x0E; r1!=r2 -> PCSelD=0.
//  - BEQ with ForwardAD=1, ALUOutM equal to r2 -> PCSelD=1; J 0x3FFFFFF, PCp1D=0xFC000005 -> PCJumpD=0xFFFFFFFF.
//  - EN=0 two cycles: *E held; FlushE=1 with EN=0 -> all *E 0 next edge.
//  - Opcode 0x05 -> with DECODE_BNE_EN taken iff r1!=r2; without it IllegalE=1, RegWriteE=0, PCSelD=0.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: register file, control decoder, early branch resolution and ID/EX register.
// Optional BNE support is enabled by defining DECODE_BNE_EN.
module decode_stage #(
    parameter int unsigned DWL  = 32,
    parameter int unsigned RAWL = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic            FlushE,
    input  logic [DWL-1:0]  InstrD,
    input  logic [DWL-1:0]  PCp1D,
    input  logic            RegWriteW,
    input  logic [RAWL-1:0] WriteRegW,
    input  logic [DWL-1:0]  ResultW,
    input  logic [DWL-1:0]  ALUOutM,
    input  logic            ForwardAD,
    input  logic            ForwardBD,
    output logic            PCSelD,
    output logic            JumpD,
    output logic [DWL-1:0]  PCBranchD,
    output logic [DWL-1:0]  PCJumpD,
    output logic            BranchD,
    output logic [RAWL-1:0] RsD,
    output logic [RAWL-1:0] RtD,
    output logic            RegWriteE,
    output logic            MemtoRegE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            RegDstE,
    output logic [2:0]      ALUControlE,
    output logic [DWL-1:0]  RD1E,
    output logic [DWL-1:0]  RD2E,
    output logic [DWL-1:0]  SignImmE,
    output logic [RAWL-1:0] RsE,
    output logic [RAWL-1:0] RtE,
    output logic [RAWL-1:0] RdE,
    output logic            IllegalE
);
    localparam int unsigned NREG = 2 ** RAWL;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
`ifdef DECODE_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'h05;
`endif
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [5:0]      opD;
    logic [5:0]      functD;
    logic [RAWL-1:0] rdD;
    logic [DWL-1:0]  signImmD;
    logic [DWL-1:0]  rd1;
    logic [DWL-1:0]  rd2;
    logic [DWL-1:0]  cmpA;
    logic [DWL-1:0]  cmpB;
    logic            regWriteD, memtoRegD, memWriteD, aluSrcD, regDstD, illegalD, bneD;
    logic [2:0]      aluControlD;
    logic [DWL-1:0]  rf [NREG];

    assign opD      = InstrD[31:26];
    assign functD   = InstrD[5:0];
    assign RsD      = InstrD[25:21];
    assign RtD      = InstrD[20:16];
    assign rdD      = InstrD[15:11];
    assign signImmD = {{(DWL-16){InstrD[15]}}, InstrD[15:0]};

    // Register file; r0 is never written.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else if (RegWriteW && WriteRegW != '0) begin
            rf[WriteRegW] <= ResultW;
        end
    end

    // Reads see the writeback value in the same cycle; everything reads 0 while in reset.
    assign rd1 = (!RST_N || RsD == '0) ? '0 :
                 (RegWriteW && WriteRegW == RsD) ? ResultW : rf[RsD];
    assign rd2 = (!RST_N || RtD == '0) ? '0 :
                 (RegWriteW && WriteRegW == RtD) ? ResultW : rf[RtD];

    // Main and ALU control decode; anything undefined becomes a flagged NOP.
    always_comb begin
        regWriteD   = 1'b0;
        memtoRegD   = 1'b0;
        memWriteD   = 1'b0;
        aluSrcD     = 1'b0;
        regDstD     = 1'b0;
        BranchD     = 1'b0;
        JumpD       = 1'b0;
        bneD        = 1'b0;
        aluControlD = ALU_AND;
        illegalD    = 1'b0;
        case (opD)
            OP_R: begin
                regWriteD = 1'b1;
                regDstD   = 1'b1;
                case (functD)
                    FN_ADD:  aluControlD = ALU_ADD;
                    FN_SUB:  aluControlD = ALU_SUB;
                    FN_AND:  aluControlD = ALU_AND;
                    FN_OR:   aluControlD = ALU_OR;
                    FN_SLT:  aluControlD = ALU_SLT;
                    default: begin
                        regWriteD = 1'b0;
                        regDstD   = 1'b0;
                        illegalD  = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                regWriteD   = 1'b1;
                memtoRegD   = 1'b1;
                aluSrcD     = 1'b1;
                aluControlD = ALU_ADD;
            end
            OP_SW: begin
                memWriteD   = 1'b1;
                aluSrcD     = 1'b1;
                aluControlD = ALU_ADD;
            end
            OP_BEQ: begin
                BranchD     = 1'b1;
                aluControlD = ALU_SUB;
            end
`ifdef DECODE_BNE_EN
            OP_BNE: begin
                BranchD     = 1'b1;
                bneD        = 1'b1;
                aluControlD = ALU_SUB;
            end
`endif
            OP_ADDI: begin
                regWriteD   = 1'b1;
                aluSrcD     = 1'b1;
                aluControlD = ALU_ADD;
            end
            OP_J:    JumpD = 1'b1;
            default: illegalD = 1'b1;
        endcase
    end

    // Early branch resolution and redirect targets for Fetch.
    assign cmpA      = ForwardAD ? ALUOutM : rd1;
    assign cmpB      = ForwardBD ? ALUOutM : rd2;
    assign PCSelD    = BranchD && (bneD ? (cmpA != cmpB) : (cmpA == cmpB));
    assign PCBranchD = PCp1D + signImmD;
    assign PCJumpD   = {PCp1D[DWL-1:26], InstrD[25:0]};

    // ID/EX register: flush beats enable.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N || FlushE) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= 3'b000;
            RD1E        <= '0;
            RD2E        <= '0;
            SignImmE    <= '0;
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
            IllegalE    <= 1'b0;
        end else if (EN) begin
            RegWriteE   <= regWriteD;
            MemtoRegE   <= memtoRegD;
            MemWriteE   <= memWriteD;
            ALUSrcE     <= aluSrcD;
            RegDstE     <= regDstD;
            ALUControlE <= aluControlD;
            RD1E        <= rd1;
            RD2E        <= rd2;
            SignImmE    <= signImmD;
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= rdD;
            IllegalE    <= illegalD;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; follows DECODE_BNE_EN like the RTL.
module tb_decode_stage;
    logic        CLK, RST_N, EN, FlushE;
    logic [31:0] InstrD, PCp1D, ResultW, ALUOutM;
    logic        RegWriteW, ForwardAD, ForwardBD;
    logic [4:0]  WriteRegW;
    logic        PCSelD, JumpD, BranchD;
    logic [31:0] PCBranchD, PCJumpD;
    logic [4:0]  RsD, RtD, RsE, RtE, RdE;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, IllegalE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [8:0]  ctrlE;
    int          checks = 0;
    int          errors = 0;

    decode_stage #(.DWL(32), .RAWL(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .FlushE(FlushE),
        .InstrD(InstrD), .PCp1D(PCp1D),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .PCSelD(PCSelD), .JumpD(JumpD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
        .BranchD(BranchD), .RsD(RsD), .RtD(RtD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .IllegalE(IllegalE)
    );

    assign ctrlE = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, IllegalE};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rIns(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iIns(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wrReg(input logic [4:0] r, input logic [31:0] v);
        RegWriteW = 1'b1; WriteRegW = r; ResultW = v;
        step();
        RegWriteW = 1'b0;
    endtask

    // Control vector {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,ALUControl[2:0],Illegal}
    logic [31:0] vecIns [12];
    logic [8:0]  vecCtl [12];
    string       vecTag [12];

    initial begin
        vecIns[0]  = rIns(1, 2, 3, 6'h20);       vecCtl[0]  = 9'b1_0_0_0_1_010_0; vecTag[0]  = "add";
        vecIns[1]  = rIns(1, 2, 3, 6'h22);       vecCtl[1]  = 9'b1_0_0_0_1_110_0; vecTag[1]  = "sub";
        vecIns[2]  = rIns(1, 2, 3, 6'h24);       vecCtl[2]  = 9'b1_0_0_0_1_000_0; vecTag[2]  = "and";
        vecIns[3]  = rIns(1, 2, 3, 6'h25);       vecCtl[3]  = 9'b1_0_0_0_1_001_0; vecTag[3]  = "or";
        vecIns[4]  = rIns(1, 2, 3, 6'h2A);       vecCtl[4]  = 9'b1_0_0_0_1_111_0; vecTag[4]  = "slt";
        vecIns[5]  = iIns(6'h23, 1, 4, 16'h0008); vecCtl[5] = 9'b1_1_0_1_0_010_0; vecTag[5]  = "lw";
        vecIns[6]  = iIns(6'h2B, 1, 4, 16'h0008); vecCtl[6] = 9'b0_0_1_1_0_010_0; vecTag[6]  = "sw";
        vecIns[7]  = iIns(6'h08, 1, 4, 16'h8000); vecCtl[7] = 9'b1_0_0_1_0_010_0; vecTag[7]  = "addi";
        vecIns[8]  = iIns(6'h04, 1, 2, 16'h0001); vecCtl[8] = 9'b0_0_0_0_0_110_0; vecTag[8]  = "beq";
        vecIns[9]  = {6'h02, 26'h0000123};        vecCtl[9] = 9'b0_0_0_0_0_000_0; vecTag[9]  = "j";
        vecIns[10] = rIns(1, 2, 3, 6'h21);       vecCtl[10] = 9'b0_0_0_0_0_000_1; vecTag[10] = "badfunct";
        vecIns[11] = iIns(6'h3F, 1, 2, 16'h0000); vecCtl[11] = 9'b0_0_0_0_0_000_1; vecTag[11] = "badop";
    end

    initial begin
        RST_N = 1'b0; EN = 1'b1; FlushE = 1'b0; InstrD = '0; PCp1D = '0;
        RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0; ALUOutM = '0;
        ForwardAD = 1'b0; ForwardBD = 1'b0;
        #2;
        check("rst_ctrl", 32'(ctrlE), 32'h0);
        check("rst_rd1e", RD1E, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        step();

        wrReg(5'd1, 32'h55);
        wrReg(5'd2, 32'h55);
        wrReg(5'd3, 32'h77);

        // Same-cycle write-through bypass
        RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'h1234;
        InstrD = rIns(5, 0, 6, 6'h20);
        step();
        RegWriteW = 1'b0;
        check("bypass_rd1e", RD1E, 32'h1234);
        check("bypass_rse", 32'(RsE), 32'd5);
        check("bypass_rde", 32'(RdE), 32'd6);

        // r0 ignores writes
        wrReg(5'd0, 32'hDEAD);
        InstrD = rIns(0, 3, 7, 6'h20);
        step();
        check("r0_rd1e", RD1E, 32'h0);
        check("r3_rd2e", RD2E, 32'h77);

        // BEQ taken / not taken, backward target
        PCp1D = 32'h10;
        InstrD = iIns(6'h04, 1, 2, 16'hFFFE);
        #1;
        check("beq_eq_sel", 32'(PCSelD), 32'd1);
        check("beq_target", PCBranchD, 32'h0000000E);
        check("beq_branchd", 32'(BranchD), 32'd1);
        check("beq_rsd", 32'(RsD), 32'd1);
        check("beq_rtd", 32'(RtD), 32'd2);
        step();
        check("beq_signimme", SignImmE, 32'hFFFFFFFE);
        InstrD = iIns(6'h04, 1, 3, 16'hFFFE);
        #1;
        check("beq_ne_sel", 32'(PCSelD), 32'd0);

        // Forwarded compare operand
        InstrD = iIns(6'h04, 3, 2, 16'h0004);
        #1;
        check("beq_nofwd_sel", 32'(PCSelD), 32'd0);
        ForwardAD = 1'b1; ALUOutM = 32'h55;
        #1;
        check("beq_fwd_sel", 32'(PCSelD), 32'd1);
        ForwardAD = 1'b0;
        ForwardBD = 1'b1; ALUOutM = 32'h77;
        #1;
        check("beq_fwdb_sel", 32'(PCSelD), 32'd1);
        ForwardBD = 1'b0; ALUOutM = '0;

        // Jump target concatenation
        PCp1D = 32'hFC000005;
        InstrD = {6'h02, 26'h3FFFFFF};
        #1;
        check("j_jumpd", 32'(JumpD), 32'd1);
        check("j_target", PCJumpD, 32'hFFFFFFFF);
        check("j_sel", 32'(PCSelD), 32'd0);

        // Decode table through the ID/EX register
        for (int i = 0; i < 12; i++) begin
            InstrD = vecIns[i];
            step();
            check(vecTag[i], 32'(ctrlE), 32'(vecCtl[i]));
        end

        // Opcode 0x05
        InstrD = iIns(6'h05, 1, 3, 16'h0002);
        #1;
`ifdef DECODE_BNE_EN
        check("bne_ne_sel", 32'(PCSelD), 32'd1);
`else
        check("bne_ne_sel", 32'(PCSelD), 32'd0);
`endif
        step();
`ifdef DECODE_BNE_EN
        check("bne_ctrl", 32'(ctrlE), 32'(9'b0_0_0_0_0_110_0));
`else
        check("bne_ctrl", 32'(ctrlE), 32'(9'b0_0_0_0_0_000_1));
`endif
        InstrD = iIns(6'h05, 1, 2, 16'h0002);
        #1;
        check("bne_eq_sel", 32'(PCSelD), 32'd0);

        // Stall hold then flush bubble
        InstrD = rIns(1, 2, 6, 6'h20);
        step();
        EN = 1'b0;
        InstrD = iIns(6'h23, 3, 4, 16'h0008);
        step();
        step();
        check("hold_ctrl", 32'(ctrlE), 32'(9'b1_0_0_0_1_010_0));
        check("hold_rde", 32'(RdE), 32'd6);
        check("hold_rd1e", RD1E, 32'h55);
        FlushE = 1'b1;
        step();
        check("flush_ctrl", 32'(ctrlE), 32'h0);
        check("flush_rd1e", RD1E, 32'h0);
        check("flush_rse", 32'(RsE), 32'h0);
        FlushE = 1'b0; EN = 1'b1;

        // Asynchronous reset mid-run
        InstrD = rIns(1, 2, 6, 6'h20);
        step();
        check("pre_rst_rd1e", RD1E, 32'h55);
        InstrD = iIns(6'h04, 1, 0, 16'h0000);
        #1;
        check("pre_rst_sel", 32'(PCSelD), 32'd0);
        RST_N = 1'b0;
        #1;
        check("async_rst_rd1e", RD1E, 32'h0);
        check("async_rst_ctrl", 32'(ctrlE), 32'h0);
        check("async_rst_sel", 32'(PCSelD), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("post_rst_sel", 32'(PCSelD), 32'd1);
        InstrD = rIns(1, 3, 6, 6'h20);
        step();
        check("post_rst_rd1e", RD1E, 32'h0);
        check("post_rst_rd2e", RD2E, 32'h0);
        check("post_rst_ctrl", 32'(ctrlE), 32'(9'b1_0_0_0_1_010_0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
